// File: rtl/thold_spike_stage.sv
// rtl/thold_spike_stage.sv - threshold shadow/active banks plus 2-stage spike compare pipeline
//
// Purpose:
//   Captures 3-byte threshold sets from the loader write port into a shadow
//   bank and commits them atomically to the active bank. A valid/ready
//   pipeline (S1 lookup, S2 compare) flags neurons whose membrane potential
//   reached the layer threshold and applies reset-by-subtraction.
//
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   Sram_We, Sram_addr, Sram_Data   threshold byte write port (addr 3 illegal)
//   in_valid/in_ready               sample handshake
//   in_layer, in_idx, in_pot        sample layer, neuron index, signed potential
//   out_valid/out_ready             result handshake
//   out_layer, out_idx              passed-through layer and index
//   out_spike, out_pot              spike flag, potential after subtraction
//   set_loaded                      sticky: a full set has been committed
//   commit                          one-cycle pulse on active bank update
//   cfg_err                         sticky configuration error

module thold_spike_stage #(
  parameter int         POT_W     = 16,
  parameter logic [7:0] DEF_THOLD = 8'd64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Sram_We,
  input  logic [1:0]       Sram_addr,
  input  logic [7:0]       Sram_Data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_layer,
  input  logic [7:0]       in_idx,
  input  logic [POT_W-1:0] in_pot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_layer,
  output logic [7:0]       out_idx,
  output logic             out_spike,
  output logic [POT_W-1:0] out_pot,
  output logic             set_loaded,
  output logic             commit,
  output logic             cfg_err
);

  // Only bytes 0 and 1 need shadow storage: the addr-2 byte completes the
  // set and is forwarded straight into the active bank on the same edge.
  logic [7:0] shadow_0, shadow_1;
  logic [1:0] mask;
  logic [7:0] active_0, active_1, active_2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_0   <= 8'd0;
      shadow_1   <= 8'd0;
      mask       <= 2'b00;
      active_0   <= DEF_THOLD;
      active_1   <= DEF_THOLD;
      active_2   <= DEF_THOLD;
      commit     <= 1'b0;
      set_loaded <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (Sram_We) begin
        case (Sram_addr)
          2'd0: begin
            shadow_0 <= Sram_Data;
            mask[0]  <= 1'b1;
          end
          2'd1: begin
            shadow_1 <= Sram_Data;
            mask[1]  <= 1'b1;
          end
          2'd2: begin
            // Closing byte: either commits a complete set or flags the
            // partial set as an error; both paths start a fresh set.
            mask <= 2'b00;
            if (&mask) begin
              active_0   <= shadow_0;
              active_1   <= shadow_1;
              active_2   <= Sram_Data;
              commit     <= 1'b1;
              set_loaded <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
          default: cfg_err <= 1'b1;
        endcase
      end
    end
  end

  // Pipeline control: S2 is the output register.
  logic             s1_valid;
  logic [1:0]       s1_layer;
  logic [7:0]       s1_idx;
  logic [POT_W-1:0] s1_pot;
  logic [7:0]       s1_thold;
  logic             s1_adv;

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  logic [7:0] lk_thold;
  always_comb begin
    lk_thold = 8'd0;
    case (in_layer)
      2'd0:    lk_thold = active_0;
      2'd1:    lk_thold = active_1;
      2'd2:    lk_thold = active_2;
      default: lk_thold = 8'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_layer <= 2'd0;
      s1_idx   <= 8'd0;
      s1_pot   <= '0;
      s1_thold <= 8'd0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_layer <= in_layer;
        s1_idx   <= in_idx;
        s1_pot   <= in_pot;
        s1_thold <= lk_thold;
      end
    end
  end

  // Threshold is non-negative and POT_W >= 10, so the zero-extended value
  // is a valid positive signed operand and pot - thold cannot overflow.
  logic [POT_W-1:0] thold_ext;
  logic             s1_spike;
  logic [POT_W-1:0] s1_res;

  always_comb begin
    thold_ext = {{(POT_W-8){1'b0}}, s1_thold};
    s1_spike  = (s1_layer != 2'd3) && ($signed(s1_pot) >= $signed(thold_ext));
    s1_res    = s1_spike ? (s1_pot - thold_ext) : s1_pot;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_layer <= 2'd0;
      out_idx   <= 8'd0;
      out_spike <= 1'b0;
      out_pot   <= '0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_layer <= s1_layer;
        out_idx   <= s1_idx;
        out_spike <= s1_spike;
        out_pot   <= s1_res;
      end
    end
  end

endmodule
